// File: rtl/class_argmax_if.sv
// Score-pair input stream and argmax result stream for class_argmax.
interface class_argmax_if #(
  parameter int unsigned NUM_CLASSES = 1000,
  parameter int unsigned DATA_W      = 16
);
  localparam int unsigned CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic              in_valid;
  logic [DATA_W-1:0] score_a;
  logic [DATA_W-1:0] score_b;
  logic              in_ready;
  logic              out_valid;
  logic [CLS_W-1:0]  out_class;
  logic [DATA_W-1:0] out_score;
  logic              out_ready;

  // Producer/consumer side
  modport master (
    output in_valid, score_a, score_b, out_ready,
    input  in_ready, out_valid, out_class, out_score
  );

  // Argmax block side
  modport slave (
    input  in_valid, score_a, score_b, out_ready,
    output in_ready, out_valid, out_class, out_score
  );
endinterface

// File: rtl/class_argmax.sv
// Streaming argmax over NUM_CLASSES signed scores, delivered two per beat
// (even class in score_a, odd class in score_b). Ties resolve to the lower index.
module class_argmax #(
  parameter int unsigned NUM_CLASSES = 1000,
  parameter int unsigned DATA_W      = 16
) (
  input logic          clk,
  input logic          rst,
  class_argmax_if.slave bus
);
  localparam int unsigned CLS_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned NUM_PAIRS = NUM_CLASSES / 2;
  localparam int unsigned K_W       = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [K_W-1:0] LAST_K = K_W'(NUM_PAIRS - 1);

  typedef enum logic [0:0] {StAccum, StDone} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [K_W-1:0]     r_k;
  logic [DATA_W-1:0]  r_max;
  logic [CLS_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_out_score;
  logic [CLS_W-1:0]   r_out_class;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_beat;
  logic               w_last;
  logic               w_a_wins;
  logic [DATA_W-1:0]  w_pair_max;
  logic [CLS_W-1:0]   w_pair_idx;
  logic               w_take;
  logic [DATA_W-1:0]  w_win_max;
  logic [CLS_W-1:0]   w_win_idx;

  assign w_beat = bus.in_valid & w_in_ready;
  assign w_last = (r_k == LAST_K);

  // Pair winner and running-max merge; first pair of a frame loads unconditionally
  always_comb begin
    w_a_wins   = ($signed(bus.score_a) >= $signed(bus.score_b));
    w_pair_max = w_a_wins ? bus.score_a : bus.score_b;
    w_pair_idx = CLS_W'({r_k, ~w_a_wins});
    w_take     = (r_k == '0) || ($signed(w_pair_max) > $signed(r_max));
    w_win_max  = w_take ? w_pair_max : r_max;
    w_win_idx  = w_take ? w_pair_idx : r_idx;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= StAccum;
    else     r_state <= w_state_next;
  end

  // Next-state: finish on the last beat, return on result handshake
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StAccum: if (w_beat && w_last) w_state_next = StDone;
      StDone:  if (bus.out_ready)     w_state_next = StAccum;
      default: w_state_next = StAccum;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      StAccum: w_in_ready  = 1'b1;
      StDone:  w_out_valid = 1'b1;
      default: w_in_ready  = 1'b0;
    endcase
  end

  // Pair counter, running max and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_max       <= '0;
      r_idx       <= '0;
      r_out_score <= '0;
      r_out_class <= '0;
    end else if (w_beat) begin
      r_max <= w_win_max;
      r_idx <= w_win_idx;
      if (w_last) begin
        r_out_score <= w_win_max;
        r_out_class <= w_win_idx;
        r_k         <= '0;
      end else begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_score = r_out_score;
  assign bus.out_class = r_out_class;
endmodule

// File: tb/tb_class_argmax.sv
// Directed bench for class_argmax with NUM_CLASSES=8, DATA_W=16.
module tb_class_argmax;
  localparam int unsigned NC = 8;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  class_argmax_if #(.NUM_CLASSES(NC), .DATA_W(DW)) bus ();

  class_argmax #(.NUM_CLASSES(NC), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int a[4];
    int b[4];
    int cls;
    int sc;
  } vec_t;

  vec_t tbl[6];

  function automatic vec_t mk(input int a0, input int b0, input int a1, input int b1,
                              input int a2, input int b2, input int a3, input int b3,
                              input int cls, input int sc);
    vec_t v;
    v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1;
    v.a[2] = a2; v.b[2] = b2; v.a[3] = a3; v.b[3] = b3;
    v.cls = cls; v.sc = sc & 32'hFFFF;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat: present the pair and let one edge pass; in_valid drops afterwards
  task automatic send_pair(input int a, input int b);
    bus.in_valid = 1'b1;
    bus.score_a  = 16'(a);
    bus.score_b  = 16'(b);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_result(input string name, input int cls, input int sc);
    chk({name, ".out_valid"}, int'(bus.out_valid), 1);
    chk({name, ".in_ready"},  int'(bus.in_ready), 0);
    chk({name, ".out_class"}, int'(bus.out_class), cls);
    chk({name, ".out_score"}, int'(bus.out_score), sc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int p;
    int ov_cycles;
    int ov_rises;
    int bubbles;
    int prev_ov;
    int res_cls[2];
    int res_sc[2];
    int nres;
    int fa[8];
    int fb[8];

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.score_a   = '0;
    bus.score_b   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset.in_ready",  int'(bus.in_ready), 1);
    chk("reset.out_valid", int'(bus.out_valid), 0);
    chk("reset.out_class", int'(bus.out_class), 0);
    chk("reset.out_score", int'(bus.out_score), 0);

    tbl[0] = mk(3, 7, 2, 1, 9, 4, 0, 5, 4, 9);
    tbl[1] = mk(-5, -5, -9, -6, -5, -7, -8, -20, 0, -5);
    tbl[2] = mk(1, 2, 3, 4, 5, 6, 7, 8, 7, 8);
    tbl[3] = mk(50, 1, 2, 3, 4, 5, 6, 7, 0, 50);
    tbl[4] = mk(1, 1, 10, 10, 0, 10, -1, -2, 2, 10);
    tbl[5] = mk(-32768, -32768, -32768, -32768, 0, 0, 32767, -32768, 6, 32767);

    // Table-driven frames, result checked 1 cycle after the 4th beat
    for (int t = 0; t < 6; t++) begin
      string nm;
      nm = $sformatf("vec%0d", t);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (i == 3) chk({nm, ".ov_before_last"}, int'(bus.out_valid), 0);
        send_pair(tbl[t].a[i], tbl[t].b[i]);
      end
      check_result(nm, tbl[t].cls, tbl[t].sc);
      tick();
      chk({nm, ".in_ready_after"},  int'(bus.in_ready), 1);
      chk({nm, ".out_valid_after"}, int'(bus.out_valid), 0);
    end

    // Backpressure with gaps; garbage offered while idle and while DONE
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_pair(tbl[0].a[i], tbl[0].b[i]);
      if (i < 3) begin
        bus.in_valid = 1'b0;
        bus.score_a  = 16'd1000;
        bus.score_b  = 16'd1000;
        tick();
      end
    end
    for (int c = 0; c < 5; c++) begin
      check_result($sformatf("bp%0d", c), 4, 9);
      bus.in_valid = 1'b1;
      bus.score_a  = 16'd1000;
      bus.score_b  = 16'd1000;
      tick();
    end
    check_result("bp5", 4, 9);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp.in_ready_after", int'(bus.in_ready), 1);
    for (int i = 0; i < 4; i++) send_pair(tbl[2].a[i], tbl[2].b[i]);
    check_result("bp.next", 7, 8);
    tick();

    // Reset mid-frame, asserted together with a would-be beat
    send_pair(100, 100);
    send_pair(100, 100);
    bus.in_valid = 1'b1;
    bus.score_a  = 16'd200;
    bus.score_b  = 16'd200;
    do_reset();
    bus.in_valid = 1'b0;
    chk("rstmid.in_ready",  int'(bus.in_ready), 1);
    chk("rstmid.out_valid", int'(bus.out_valid), 0);
    chk("rstmid.out_score", int'(bus.out_score), 0);
    for (int i = 0; i < 4; i++) send_pair(tbl[2].a[i], tbl[2].b[i]);
    check_result("rstmid", 7, 8);
    tick();

    // Reset while DONE drops the pending result
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(tbl[0].a[i], tbl[0].b[i]);
    check_result("rstdone.pre", 4, 9);
    do_reset();
    chk("rstdone.out_valid", int'(bus.out_valid), 0);
    chk("rstdone.in_ready",  int'(bus.in_ready), 1);
    chk("rstdone.out_class", int'(bus.out_class), 0);
    chk("rstdone.out_score", int'(bus.out_score), 0);
    bus.out_ready = 1'b1;

    // Back-to-back frames with in_valid and out_ready held high
    fa = '{10, 30, 50, 70, 90, 12, 14, 16};
    fb = '{20, 40, 60, 80, 11, 13, 15, 17};
    p = 0; ov_cycles = 0; ov_rises = 0; bubbles = 0; prev_ov = 0; nres = 0;
    for (int c = 0; c < 14; c++) begin
      logic beat;
      bus.in_valid = (p < 8);
      bus.score_a  = 16'(fa[p % 8]);
      bus.score_b  = 16'(fb[p % 8]);
      beat = bus.in_ready && (p < 8);
      tick();
      if (beat) p++;
      if (bus.out_valid) begin
        ov_cycles++;
        if (prev_ov == 0) ov_rises++;
        if (nres < 2) begin
          res_cls[nres] = int'(bus.out_class);
          res_sc[nres]  = int'(bus.out_score);
        end
        nres++;
      end
      if (!bus.in_ready && p < 8) bubbles++;
      prev_ov = int'(bus.out_valid);
    end
    bus.in_valid = 1'b0;
    chk("b2b.pairs_taken", p, 8);
    chk("b2b.results",     nres, 2);
    chk("b2b.ov_cycles",   ov_cycles, 2);
    chk("b2b.ov_rises",    ov_rises, 2);
    chk("b2b.bubbles",     bubbles, 1);
    if (nres >= 2) begin
      chk("b2b.class0", res_cls[0], 7);
      chk("b2b.score0", res_sc[0], 80);
      chk("b2b.class1", res_cls[1], 0);
      chk("b2b.score1", res_sc[1], 90);
    end else begin
      chk("b2b.results_present", nres, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end
endmodule
